// File: rtl/fifo_alu_reader.sv
// fifo_alu_reader: pops opcode/A/B frames from a show-ahead FIFO and presents ALU results on a valid/ready port
module fifo_alu_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    input  logic                  soft_clr,
    input  logic                  res_ready,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_carry,
    output logic                  res_zero,
    output logic                  res_err,
    output logic [CNT_WIDTH-1:0]  op_count,
    output logic                  busy
);
    typedef enum logic [1:0] {GET_OP, GET_A, GET_B, RESULT} state_t;
    state_t                state;
    logic [DATA_WIDTH-1:0] op_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] sh;
    logic [DATA_WIDTH:0]   alu;
    logic                  illegal;
    assign rd_en   = rst_n && state != RESULT && rd_valid && !soft_clr;
    assign busy    = state != GET_OP;
    assign illegal = |(op_q >> 3);
    // ALU evaluated against the B word at the FIFO head; alu holds {carry, result}
    always_comb begin
        sh  = DATA_WIDTH'(rd_data % DATA_WIDTH);
        alu = '0;
        case (op_q[2:0])
            3'd0: alu = {1'b0, a_q} + {1'b0, rd_data};
            3'd1: alu = {a_q < rd_data, a_q - rd_data};
            3'd2: alu = {1'b0, a_q & rd_data};
            3'd3: alu = {1'b0, a_q | rd_data};
            3'd4: alu = {1'b0, a_q ^ rd_data};
            3'd5: alu = {1'b0, a_q << sh};
            3'd6: alu = {1'b0, a_q >> sh};
            default: alu = {1'b0, rd_data};
        endcase
        if (illegal) alu = '0;
    end
    // Frame FSM: collect three words, register the result, hold it until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= GET_OP;
            op_q      <= '0;
            a_q       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_carry <= 1'b0;
            res_zero  <= 1'b0;
            res_err   <= 1'b0;
            op_count  <= '0;
        end else if (soft_clr) begin
            state     <= GET_OP;
            res_valid <= 1'b0;
        end else begin
            case (state)
                GET_OP: if (rd_en) begin
                    op_q  <= rd_data;
                    state <= GET_A;
                end
                GET_A: if (rd_en) begin
                    a_q   <= rd_data;
                    state <= GET_B;
                end
                GET_B: if (rd_en) begin
                    res_data  <= alu[DATA_WIDTH-1:0];
                    res_carry <= alu[DATA_WIDTH];
                    res_zero  <= alu[DATA_WIDTH-1:0] == '0;
                    res_err   <= illegal;
                    res_valid <= 1'b1;
                    state     <= RESULT;
                end
                default: if (res_ready) begin
                    res_valid <= 1'b0;
                    op_count  <= op_count + 1'b1;
                    state     <= GET_OP;
                end
            endcase
        end
    end
    a_pop_needs_data: assert property (@(posedge clk) disable iff (!rst_n) rd_en |-> rd_valid);
    a_hold_result: assert property (@(posedge clk) disable iff (!rst_n)
        res_valid && !res_ready && !soft_clr |=> $stable({res_valid, res_data, res_carry, res_zero, res_err}));
    a_result_state: assert property (@(posedge clk) disable iff (!rst_n) (state == RESULT) == res_valid);
endmodule

// File: doc/fifo_alu_reader.md
Name: fifo_alu_reader

Overview:
- Consumer on the FIFO read interface.
- Pops 3-word command frames from the FIFO and executes one ALU operation per frame. Frame order: opcode, operand A, operand B.
- Presents each result on a registered valid/ready output port.
- Sits directly downstream of the FIFO. It is the read-side counterpart to the producer writing commands into the FIFO.

Parameters:
- DATA_WIDTH, 8, width of FIFO words, operands and result.
- CNT_WIDTH, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rd_valid  input  1  FIFO has data (non-empty).
- rd_data  input  DATA_WIDTH  FIFO head word; show-ahead, valid while rd_valid=1.
- rd_en  output  1  pop request; word is consumed at the edge where rd_en&&rd_valid.
- soft_clr  input  1  synchronous abort of the current frame/result.
- res_ready  input  1  downstream accepts result.
- res_valid  output  1  result registers hold an unaccepted result.
- res_data  output  DATA_WIDTH  result value.
- res_carry  output  1  carry/borrow flag.
- res_zero  output  1  res_data==0.
- res_err  output  1  illegal opcode flag.
- op_count  output  CNT_WIDTH  number of results accepted downstream.
- busy  output  1  state != GET_OP.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=GET_OP.
  - res_valid=0, res_data=0, res_carry=0, res_zero=0, res_err=0.
  - op_count=0, internal opcode/A registers=0.
  - rd_en=0 while in reset.
- States: GET_OP -> GET_A -> GET_B -> RESULT -> GET_OP.
- rd_en is combinational: rd_en = (state in {GET_OP,GET_A,GET_B}) && rd_valid && !soft_clr. rd_en is never 1 while rd_valid=0 or in RESULT.
- GET_OP: on pop, latch rd_data as opcode; go to GET_A.
- GET_A: on pop, latch rd_data as A; go to GET_B.
- GET_B: on pop, compute with B=rd_data in the same cycle, register all res_* outputs, set res_valid=1; go to RESULT.
  - Latency: result visible the cycle after the B pop.
- In any GET state, rd_valid=0 means hold state. Stalls of any length never corrupt the partial frame.
- RESULT:
  - Outputs are held stable while res_valid && !res_ready.
  - On res_valid&&res_ready: res_valid<=0, op_count<=op_count+1 (wraps at 2^CNT_WIDTH), go to GET_OP.
  - No pop occurs in the acceptance cycle. Minimum 4 cycles per operation.
- Opcode decode uses opcode[2:0]:
  - 0 ADD: {carry,res}=A+B, carry is bit DATA_WIDTH.
  - 1 SUB: res=A-B mod 2^DATA_WIDTH, carry=(A<B) unsigned borrow.
  - 2 AND, 3 OR, 4 XOR: carry=0.
  - 5 SHL: res=A<<(B mod DATA_WIDTH), carry=0.
  - 6 SHR logical: res=A>>(B mod DATA_WIDTH), carry=0.
  - 7 PASSB: res=B, carry=0.
- Illegal opcode (any opcode bit above [2:0] nonzero): res=0, carry=0, res_err=1. The frame is still fully consumed (A and B popped) so stream alignment is preserved. res_err=0 for legal opcodes.
- res_zero=(res==0) for every result, including error results.
- soft_clr=1 (synchronous, highest priority after reset):
  - Next state GET_OP, res_valid<=0, partial frame discarded.
  - No pop in that cycle; op_count unchanged.
- Reset mid-frame behaves like soft_clr but also clears all registers. Words already popped are lost by design.
- Required assertions:
  - rd_en |-> rd_valid.
  - res_valid && !res_ready |=> $stable({res_valid, res_data, res_carry, res_zero, res_err}).
  - state==RESULT <-> res_valid.

Test Plan:
- ADD frame 0x00,0xF0,0x20 with res_ready=1 -> res_valid 1 cycle after 3rd pop, res_data=0x10, carry=1, zero=0, err=0; op_count=1.
- SUB frame 0x01,0x05,0x07 then AND frame 0x02,0x0F,0xF0 -> first 0xFE carry=1; second 0x00 zero=1 carry=0; op_count=2.
- Backpressure: frame 0x05,0x81,0x01 (SHL -> 0x02), res_ready=0 for 6 cycles -> outputs stable, rd_en=0 throughout while the FIFO is non-empty; accepted on res_ready=1.
- Starvation: push 0x07,0x11, leave FIFO empty 10 cycles, push 0x3C -> rd_en=0 during gap, result 0x3C (PASSB), busy=1 during gap.
- Illegal opcode 0x08,0xAA,0xBB followed by ADD 0x00,0x01,0x01 -> first result res_err=1 data=0x00 zero=1; second 0x02 err=0. Proves alignment is kept.
- soft_clr after opcode+A popped, then full ADD frame 0x00,0x03,0x04 -> no result for the aborted frame, next result 0x07. Repeat with rst_n pulsed mid-frame -> all outputs 0 immediately, op_count=0.
